// File: rtl/cc_cond_unit.sv
// Y86-64 execute stage: condition-code register, jXX/cmovXX evaluator and E->M register.
// Define CC_BAD_COND_EN to add the sticky bad_cond flag for condition selectors above 6.
module cc_cond_unit #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [DATA_W-1:0] valE,
  input  logic              alu_of,
  input  logic              cc_block,
  input  logic              stall,
  input  logic              bubble,
  output logic              zf,
  output logic              sf,
  output logic              of,
  output logic              cnd,
  output logic              out_valid,
  output logic [3:0]        out_icode,
  output logic [DATA_W-1:0] out_valE,
  output logic              out_cnd,
  output logic              bad_cond
);

  localparam logic [3:0] ICODE_OPQ  = 4'h6;
  localparam logic [3:0] ICODE_JXX  = 4'h7;
  localparam logic [3:0] ICODE_CMOV = 4'h2;
  localparam logic [3:0] ICODE_NOP  = 4'h1;

  function automatic logic cond_eval(input logic [3:0] fn, input logic z,
                                     input logic s, input logic o);
    logic r;
    case (fn)
      4'd0:    r = 1'b1;
      4'd1:    r = (s ^ o) | z;
      4'd2:    r = s ^ o;
      4'd3:    r = z;
      4'd4:    r = ~z;
      4'd5:    r = ~(s ^ o);
      4'd6:    r = ~(s ^ o) & ~z;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic              zf_q, zf_d, sf_q, sf_d, of_q, of_d;
  logic              out_valid_q, out_valid_d, out_cnd_q, out_cnd_d;
  logic [3:0]        out_icode_q, out_icode_d;
  logic [DATA_W-1:0] out_valE_q, out_valE_d;
  logic              set_cc, is_cond_op, cnd_c;

  assign set_cc     = in_valid & (icode == ICODE_OPQ) & ~cc_block & ~stall;
  assign is_cond_op = in_valid & ((icode == ICODE_JXX) | (icode == ICODE_CMOV));
  // Flags feeding cnd are the registered ones, so an OPq result is seen one cycle later.
  assign cnd_c      = is_cond_op & cond_eval(ifun, zf_q, sf_q, of_q);

  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (set_cc) begin
      zf_d = (valE == '0);
      sf_d = valE[DATA_W-1];
      of_d = alu_of;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_icode_d = out_icode_q;
    out_valE_d  = out_valE_q;
    out_cnd_d   = out_cnd_q;
    if (stall) begin
      out_valid_d = out_valid_q;
    end else if (bubble) begin
      out_valid_d = 1'b0;
      out_icode_d = ICODE_NOP;
      out_valE_d  = '0;
      out_cnd_d   = 1'b0;
    end else begin
      out_valid_d = in_valid;
      out_icode_d = icode;
      out_valE_d  = valE;
      out_cnd_d   = cnd_c;
    end
  end

  // Execute -> memory stage boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_icode_q <= ICODE_NOP;
      out_valE_q  <= '0;
      out_cnd_q   <= 1'b0;
    end else begin
      zf_q        <= zf_d;
      sf_q        <= sf_d;
      of_q        <= of_d;
      out_valid_q <= out_valid_d;
      out_icode_q <= out_icode_d;
      out_valE_q  <= out_valE_d;
      out_cnd_q   <= out_cnd_d;
    end
  end

`ifdef CC_BAD_COND_EN
  logic bad_cond_q, bad_cond_d;

  always_comb begin
    bad_cond_d = bad_cond_q;
    if (is_cond_op & ~stall & (ifun > 4'd6)) bad_cond_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bad_cond_q <= 1'b0;
    else       bad_cond_q <= bad_cond_d;
  end

  assign bad_cond = bad_cond_q;
`else
  assign bad_cond = 1'b0;
`endif

  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;
  assign cnd       = cnd_c;
  assign out_valid = out_valid_q;
  assign out_icode = out_icode_q;
  assign out_valE  = out_valE_q;
  assign out_cnd   = out_cnd_q;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed bench for cc_cond_unit: flags, condition evaluation, stall/bubble and async reset.
module tb_cc_cond_unit;

`ifdef CC_BAD_COND_EN
  localparam logic BADEN = 1'b1;
`else
  localparam logic BADEN = 1'b0;
`endif

  logic        clk, reset, in_valid, alu_of, cc_block, stall, bubble;
  logic [3:0]  icode, ifun;
  logic [63:0] valE;
  logic        zf, sf, of, cnd, out_valid, out_cnd, bad_cond;
  logic [3:0]  out_icode;
  logic [63:0] out_valE;

  int errors = 0;
  int checks = 0;

  cc_cond_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .icode(icode), .ifun(ifun),
    .valE(valE), .alu_of(alu_of), .cc_block(cc_block), .stall(stall), .bubble(bubble),
    .zf(zf), .sf(sf), .of(of), .cnd(cnd), .out_valid(out_valid), .out_icode(out_icode),
    .out_valE(out_valE), .out_cnd(out_cnd), .bad_cond(bad_cond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_zf"}, zf, 1);
    check({tag, "_sf"}, sf, 0);
    check({tag, "_of"}, of, 0);
    check({tag, "_ovalid"}, out_valid, 0);
    check({tag, "_oicode"}, out_icode, 4'h1);
    check({tag, "_ovalE"}, out_valE, 0);
    check({tag, "_ocnd"}, out_cnd, 0);
    check({tag, "_bad"}, bad_cond, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; icode = 4'h0; ifun = 4'h0; valE = 64'h0;
    alu_of = 1'b0; cc_block = 1'b0; stall = 1'b0; bubble = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst0");
    reset = 1'b0;

    // OPq nonzero clears zf, then OPq zero sets it
    in_valid = 1'b1; icode = 4'h6; ifun = 4'h0; valE = 64'h5; alu_of = 1'b0;
    tick;
    check("opq5_zf", zf, 0);
    check("opq5_ovalid", out_valid, 1);
    check("opq5_oicode", out_icode, 4'h6);
    check("opq5_ovalE", out_valE, 64'h5);
    check("opq5_ocnd", out_cnd, 0);
    valE = 64'h0;
    tick;
    check("opq0_zf", zf, 1);
    check("opq0_sf", sf, 0);

    // jXX e back-to-back after OPq
    icode = 4'h7; ifun = 4'h3; valE = 64'h1234;
    #1;
    check("je_cnd", cnd, 1);
    tick;
    check("je_ocnd", out_cnd, 1);
    check("je_oicode", out_icode, 4'h7);
    check("je_ovalE", out_valE, 64'h1234);
    check("je_zf_hold", zf, 1);

    // Negative result with overflow
    icode = 4'h6; valE = 64'h8000_0000_0000_0000; alu_of = 1'b1;
    tick;
    check("neg_zf", zf, 0);
    check("neg_sf", sf, 1);
    check("neg_of", of, 1);
    icode = 4'h2; ifun = 4'h2; alu_of = 1'b0; valE = 64'h7;
    #1;
    check("cmovl_cnd", cnd, 0);
    ifun = 4'h5;
    #1;
    check("cmovge_cnd", cnd, 1);
    ifun = 4'h1;
    #1;
    check("cmovle_cnd", cnd, 0);
    ifun = 4'h6;
    tick;
    check("cmovg_ocnd", out_cnd, 1);
    check("cmovg_oicode", out_icode, 4'h2);

    // cc_block suppresses flags but output still advances
    icode = 4'h6; valE = 64'h0; alu_of = 1'b0;
    tick;
    check("z2_zf", zf, 1);
    cc_block = 1'b1; valE = 64'h5; alu_of = 1'b1;
    tick;
    check("ccblk_zf", zf, 1);
    check("ccblk_of", of, 0);
    check("ccblk_ovalE", out_valE, 64'h5);
    check("ccblk_oicode", out_icode, 4'h6);

    // Stall for three cycles
    cc_block = 1'b0; alu_of = 1'b0; icode = 4'h7; ifun = 4'h0; valE = 64'hAA;
    tick;
    check("pre_stall_ovalE", out_valE, 64'hAA);
    stall = 1'b1; icode = 4'h6; valE = 64'h8000_0000_0000_0000; alu_of = 1'b1;
    tick;
    check("stall1_ovalE", out_valE, 64'hAA);
    check("stall1_oicode", out_icode, 4'h7);
    check("stall1_sf", sf, 0);
    check("stall1_of", of, 0);
    icode = 4'h2; valE = 64'hBB;
    tick;
    check("stall2_ovalE", out_valE, 64'hAA);
    in_valid = 1'b0;
    tick;
    check("stall3_ovalid", out_valid, 1);
    check("stall3_ocnd", out_cnd, 1);
    bubble = 1'b1;
    tick;
    check("stallbub_ovalid", out_valid, 1);
    check("stallbub_oicode", out_icode, 4'h7);
    stall = 1'b0; in_valid = 1'b1; icode = 4'h7; ifun = 4'h0; valE = 64'hDD;
    tick;
    check("bub_ovalid", out_valid, 0);
    check("bub_oicode", out_icode, 4'h1);
    check("bub_ovalE", out_valE, 64'h0);
    check("bub_ocnd", out_cnd, 0);
    bubble = 1'b0; valE = 64'hCC;
    #1;
    check("jmp_cnd", cnd, 1);
    tick;
    check("jmp_ocnd", out_cnd, 1);
    check("jmp_ovalid", out_valid, 1);
    check("jmp_ovalE", out_valE, 64'hCC);

    // cnd gating by in_valid and icode
    in_valid = 1'b0;
    #1;
    check("novalid_cnd", cnd, 0);
    in_valid = 1'b1; icode = 4'h6;
    #1;
    check("opq_cnd", cnd, 0);

    // Illegal condition selector
    icode = 4'h7; ifun = 4'h9;
    #1;
    check("if9_cnd", cnd, 0);
    tick;
    check("if9_bad", bad_cond, BADEN);
    check("if9_ocnd", out_cnd, 0);
    icode = 4'h2; ifun = 4'h0;
    tick;
    check("sticky_bad", bad_cond, BADEN);
    check("sticky_ovalid", out_valid, 1);

    // Asynchronous reset mid-cycle while stalled
    #2;
    stall = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_vals("rst1");
    @(negedge clk);
    reset = 1'b0; stall = 1'b0;
    icode = 4'h6; valE = 64'hFFFF_FFFF_FFFF_FFFF; alu_of = 1'b0;
    tick;
    check("post_zf", zf, 0);
    check("post_sf", sf, 1);
    check("post_of", of, 0);
    check("post_oicode", out_icode, 4'h6);
    check("post_ovalE", out_valE, 64'hFFFF_FFFF_FFFF_FFFF);
    check("post_bad", bad_cond, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cc_cond_unit.md
# cc_cond_unit

Condition-code register and branch/move condition evaluator for the Y86-64 execute stage, sitting directly downstream of the 64-bit subtractor/adder ALU. Consumes the ALU result and overflow flag, latches ZF/SF/OF on `OPq` instructions, evaluates `jXX`/`cmovXX` conditions against the stored flags, and registers the execute-stage result (icode, valE, cnd) toward the memory stage with stall/bubble control.

## Interface
- `ICODE_OPQ`, 4'h6, icode that updates condition codes
- `ICODE_JXX`, 4'h7, icode for conditional jumps
- `ICODE_CMOV`, 4'h2, icode for rrmovq/cmovXX
- `ICODE_NOP`, 4'h1, icode injected on bubble/reset
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `in_valid` in 1: execute-stage inputs carry a real instruction
- `icode` in 4: instruction code
- `ifun` in 4: function code (condition selector for jXX/cmov)
- `valE` in 64: ALU result (subtractor/adder output)
- `alu_of` in 1: ALU signed overflow
- `cc_block` in 1: suppress CC update (exception downstream)
- `stall` in 1: hold output register and CC
- `bubble` in 1: inject NOP into output register
- `zf`, `sf`, `of` out 1 each: registered condition codes
- `cnd` out 1: combinational condition for current inputs
- `out_valid` out 1, `out_icode` out 4, `out_valE` out 64, `out_cnd` out 1: registered execute→memory values
- `bad_cond` out 1: sticky illegal-condition flag (see Configuration)

## Operation
- `set_cc = in_valid & (icode==ICODE_OPQ) & ~cc_block & ~stall`.
- On `set_cc`: zf←(valE==64'h0), sf←valE[63], of←alu_of. Otherwise CC holds.
- `cnd` uses the *registered* flags (pre-update), combinational:
  - ifun 0: 1; 1 (le): (sf^of)|zf; 2 (l): sf^of; 3 (e): zf; 4 (ne): ~zf; 5 (ge): ~(sf^of); 6 (g): ~(sf^of)&~zf; 7–15: 0.
  - cnd forced 0 unless `in_valid` and icode ∈ {ICODE_JXX, ICODE_CMOV}.
- Output register per clock edge, priority high→low:
  - `stall`: all out_* hold.
  - `bubble`: out_valid←0, out_icode←ICODE_NOP, out_valE←0, out_cnd←0.
  - else: out_valid←in_valid, out_icode←icode, out_valE←valE, out_cnd←cnd.
- `stall` and `bubble` both high: stall wins (hold), CC not updated.
- `cc_block` affects only CC; output register still advances.

## Timing
- CC: updated at the edge where `set_cc` is high; visible to `cnd` the following cycle. An OPq followed back-to-back by jXX sees the OPq flags.
- Output register: 1-cycle latency from inputs to out_*.
- `cnd`: zero-cycle, combinational from ifun/icode/in_valid and flag registers.
- Reset (asynchronous, any time, including mid-stall): zf=1, sf=0, of=0, out_valid=0, out_icode=ICODE_NOP, out_valE=0, out_cnd=0, bad_cond=0. First post-reset edge with reset low behaves normally.
- valE width rule: zero test is over all 64 bits; sf is bit 63 only; no sign extension.

## Configuration
- `CC_BAD_COND_EN` defined: `bad_cond` set (sticky) at the edge where in_valid & ~stall & icode ∈ {ICODE_JXX, ICODE_CMOV} & ifun>6; cleared only by reset.
- Not defined: `bad_cond` tied 0, no sticky register; cnd still 0 for ifun>6.

## Test plan
- Reset: assert reset mid-stream with out_valid=1 → all outputs immediately at reset values (zf=1, out_icode=4'h1), independent of clk.
- OPq valE=64'h0, alu_of=0, then jXX ifun=3 → next cycle zf=1, sf=0; cnd=1, out_cnd=1 one cycle later.
- OPq valE=64'h8000_0000_0000_0000, alu_of=1, then cmov ifun=2 (l) → sf=1, of=1, cnd=0; then ifun=5 (ge) → cnd=1.
- OPq with cc_block=1, valE=5 → flags unchanged from previous (zf=1), out_valE=5 registered.
- stall=1 for 3 cycles with changing inputs → out_* and CC frozen; stall+bubble together → hold; bubble alone → out_valid=0, out_icode=4'h1.
- jXX ifun=4'h9 with CC_BAD_COND_EN → cnd=0, bad_cond=1 next edge and stays 1 until reset; without macro bad_cond stays 0.
